// File: rtl/branch_predict_unit_pkg.sv
// rv_branch_pkg: branch func3 encodings and saturating-counter init/max helpers shared by the branch unit
package rv_branch_pkg;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  function automatic int unsigned cnt_init(input int unsigned bits);
    return 32'd1 << (bits - 1);
  endfunction
  function automatic int unsigned cnt_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction
endpackage

// File: rtl/branch_predict_unit_btb_ram.sv
// btb_ram: direct-mapped BTB storage (valid/tag/target/counter); ports a_* and b_* async read, wr_* sync write, RESET_N async clear
module btb_ram #(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 4,
  parameter int TAG_BITS = 26,
  parameter int CNT_BITS = 2
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [IDX_BITS-1:0] a_idx,
  output logic                a_valid,
  output logic [TAG_BITS-1:0] a_tag,
  output logic [XLEN-1:0]     a_target,
  output logic [CNT_BITS-1:0] a_cnt,
  input  logic [IDX_BITS-1:0] b_idx,
  output logic                b_valid,
  output logic [TAG_BITS-1:0] b_tag,
  output logic [XLEN-1:0]     b_target,
  output logic [CNT_BITS-1:0] b_cnt,
  input  logic                we,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0] wr_tag,
  input  logic [XLEN-1:0]     wr_target,
  input  logic [CNT_BITS-1:0] wr_cnt
);
  localparam int N = 1 << IDX_BITS;
  logic [N-1:0]        valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q [N];
  logic [TAG_BITS-1:0] tag_d [N];
  logic [XLEN-1:0]     target_q [N];
  logic [XLEN-1:0]     target_d [N];
  logic [CNT_BITS-1:0] cnt_q [N];
  logic [CNT_BITS-1:0] cnt_d [N];
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (we) begin
      valid_d[wr_idx]  = 1'b1;
      tag_d[wr_idx]    = wr_tag;
      target_d[wr_idx] = wr_target;
      cnt_d[wr_idx]    = wr_cnt;
    end
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      valid_q  <= '0;
      tag_q    <= '{default: '0};
      target_q <= '{default: '0};
      cnt_q    <= '{default: '0};
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end
  assign a_valid  = valid_q[a_idx];
  assign a_tag    = tag_q[a_idx];
  assign a_target = target_q[a_idx];
  assign a_cnt    = cnt_q[a_idx];
  assign b_valid  = valid_q[b_idx];
  assign b_tag    = tag_q[b_idx];
  assign b_target = target_q[b_idx];
  assign b_cnt    = cnt_q[b_idx];
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: IF-side BTB prediction (if_pc -> pred_*) and EX-side branch resolution (ex_* -> registered redirect_*, branch/mispredict counters)
module branch_predict_unit
  import rv_branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int CNT_BITS    = 2,
  parameter int IDX_BITS    = $clog2(BTB_ENTRIES),
  parameter int TAG_BITS    = XLEN - IDX_BITS - 2
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic            ex_jump,
  input  logic [2:0]      ex_func3,
  input  logic [XLEN-1:0] ex_data1,
  input  logic [XLEN-1:0] ex_data2,
  input  logic [XLEN-1:0] ex_target,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispredict_cnt
);
  localparam logic [CNT_BITS-1:0] CMAX  = CNT_BITS'(cnt_max(CNT_BITS));
  localparam logic [CNT_BITS-1:0] CINIT = CNT_BITS'(cnt_init(CNT_BITS));
  logic                redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]     redirect_pc_q, redirect_pc_d;
  logic [31:0]         branch_cnt_q, branch_cnt_d, mispredict_cnt_q, mispredict_cnt_d;
  logic                if_valid, ex_valid_rd, ex_hit, res, cond, legal, taken, mispredict, we;
  logic [TAG_BITS-1:0] if_tag, ex_tag;
  logic [XLEN-1:0]     if_tgt, ex_tgt, wr_target, correct_pc;
  logic [CNT_BITS-1:0] if_cnt, ex_cnt, wr_cnt;
  btb_ram #(.XLEN(XLEN), .IDX_BITS(IDX_BITS), .TAG_BITS(TAG_BITS), .CNT_BITS(CNT_BITS)) u_btb (
    .CLK(CLK), .RESET_N(RESET_N),
    .a_idx(if_pc[IDX_BITS+1:2]), .a_valid(if_valid), .a_tag(if_tag), .a_target(if_tgt), .a_cnt(if_cnt),
    .b_idx(ex_pc[IDX_BITS+1:2]), .b_valid(ex_valid_rd), .b_tag(ex_tag), .b_target(ex_tgt), .b_cnt(ex_cnt),
    .we(we), .wr_idx(ex_pc[IDX_BITS+1:2]), .wr_tag(ex_pc[XLEN-1:IDX_BITS+2]),
    .wr_target(wr_target), .wr_cnt(wr_cnt)
  );
  assign pred_taken  = if_valid && if_tag == if_pc[XLEN-1:IDX_BITS+2] && if_cnt[CNT_BITS-1];
  assign pred_target = pred_taken ? if_tgt : if_pc + XLEN'(4);
  always_comb begin
    // EX holds a wrong-path instruction while a redirect is being presented
    res = ex_valid && (ex_branch || ex_jump) && !redirect_valid_q;
    cond = ex_func3 == F3_BEQ  ? ex_data1 == ex_data2 :
           ex_func3 == F3_BNE  ? ex_data1 != ex_data2 :
           ex_func3 == F3_BLT  ? $signed(ex_data1) <  $signed(ex_data2) :
           ex_func3 == F3_BGE  ? $signed(ex_data1) >= $signed(ex_data2) :
           ex_func3 == F3_BLTU ? ex_data1 <  ex_data2 :
           ex_func3 == F3_BGEU ? ex_data1 >= ex_data2 : 1'b0;
    legal = ex_jump || ex_func3[2] || !ex_func3[1];
    taken = ex_jump || cond;
    ex_hit = ex_valid_rd && ex_tag == ex_pc[XLEN-1:IDX_BITS+2];
    wr_cnt = ex_jump ? CMAX :
             !ex_hit ? CINIT :
             taken ? (ex_cnt == CMAX ? ex_cnt : ex_cnt + 1'b1) :
             (ex_cnt == '0 ? ex_cnt : ex_cnt - 1'b1);
    wr_target = taken ? ex_target : ex_tgt;
    we = res && legal && (ex_hit || taken);
    correct_pc = taken ? ex_target : ex_pc + XLEN'(4);
    mispredict = res && (taken != ex_pred_taken || (taken && ex_target != ex_pred_target));
    redirect_valid_d = mispredict;
    redirect_pc_d = mispredict ? correct_pc : redirect_pc_q;
    branch_cnt_d = branch_cnt_q + 32'(res && !(&branch_cnt_q));
    mispredict_cnt_d = mispredict_cnt_q + 32'(mispredict && !(&mispredict_cnt_q));
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;
endmodule
